mac_hash_table: RTL and testbench
=================================

Name: mac_hash_table

Overview:
- Parametrised successor of the crossbar MAC hash-locating block.
- Maps a 48-bit destination MAC to an outport or ToR address plus a local/remote flag.
- Table is a CRC32-hashed, set-associative array: 2^P_ADDR_WIDTH buckets × P_WAYS ways, with per-way valid bits.
- Adds over the previous generation: in-place update of existing keys, round-robin victim replacement with an overflow count, explicit hit/miss reporting, a ready/valid handshake, and a reset/flush sweep FSM. Sits between the ingress header parser and the crossbar arbiter.

Parameters:
- P_OUTPORT_WIDTH, 4, width of the outport/ToR field.
- P_ADDR_WIDTH, 4, bucket index width; bucket count = 2^P_ADDR_WIDTH.
- P_WAYS, 4, entries per bucket (1..8).
- P_ID_WIDTH, 3, width of the seek tag carried through the pipeline.
- P_AGE_WIDTH, 8, age counter width (used only with MAC_TABLE_AGING_EN).

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  synchronous, active-high reset.
- i_update_valid  in  1  update request.
- o_update_ready  out  1  update accepted when valid&&ready.
- i_update_dest_mac  in  48  key to write.
- i_update_outport  in  P_OUTPORT_WIDTH  outport/ToR value.
- i_update_flag  in  1  1 = local MAC.
- i_seek_valid  in  1  lookup request.
- o_seek_ready  out  1  lookup accepted when valid&&ready.
- i_seek_dest_mac  in  48  key to find.
- i_seek_id  in  P_ID_WIDTH  request tag.
- o_seek_valid  out  1  one-cycle result strobe.
- o_seek_hit  out  1  key found.
- o_seek_flag  out  1  stored flag (0 on miss).
- o_seek_outport  out  P_OUTPORT_WIDTH  stored outport (0 on miss).
- o_seek_id  out  P_ID_WIDTH  echoed tag (valid on hit and on miss).
- i_flush  in  1  pulse: invalidate all entries.
- o_busy  out  1  init/flush/age sweep in progress.
- o_overflow_cnt  out  16  count of valid-entry evictions; saturates at 0xFFFF.

Behaviour:
- Hash: Ethernet CRC32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final XOR) over MAC bytes [47:40]..[7:0]. Bucket index = crc[P_ADDR_WIDTH-1:0]. Computed combinationally at the accept stage and registered.
- FSM states:
  - INIT: entered on i_rst. Clears one bucket (valid bits, victim pointer) per cycle; exits to IDLE after 2^P_ADDR_WIDTH cycles.
  - IDLE: normal operation.
  - FLUSH: entered on i_flush in IDLE. Same sweep as INIT; o_overflow_cnt is kept.
  - AGE: exists only with the macro.
  - o_busy=1 and both readys=0 in every state except IDLE.
  - i_flush during a sweep restarts the sweep at bucket 0.
- Reset values: all outputs 0, o_busy=1, o_overflow_cnt=0. A reset asserted mid-operation discards in-flight seeks and updates; no o_seek_valid is emitted for them.
- Seek pipeline:
  - Accept at cycle T, bucket read/compare at T+1, registered result at T+2.
  - Throughput 1 per cycle; o_seek_ready=1 whenever IDLE.
  - Multiple matching ways (not possible by construction): lowest way wins.
- Update pipeline:
  - Accept at T, bucket read/compare at T+1, write at the end of T+1.
  - o_update_ready=0 in the cycle after an accept (max 1 update per 2 cycles).
  - Write target: matching valid way (overwrite, no eviction); else the lowest invalid way; else the way at the bucket's round-robin victim pointer. In the eviction case the pointer increments mod P_WAYS and o_overflow_cnt increments.
- Simultaneous seek and update request: seek wins, o_update_ready=0 that cycle.
- Hazard: a seek in its compare stage in the same cycle an update writes the same bucket must see the post-write contents (write-first bypass).

Optional Feature:
- Macro MAC_TABLE_AGING_EN.
- Enabled:
  - Adds input port i_age_tick (1 bit).
  - Each way gets a P_AGE_WIDTH age counter, cleared on update write and on seek hit.
  - i_age_tick in IDLE enters AGE: one bucket per cycle, each valid age increments. An entry already at max (all ones) is invalidated instead.
  - A tick arriving during any sweep is held pending and served on return to IDLE.
- Disabled: no i_age_tick port, no age storage; entries persist until overwritten, evicted or flushed.

Decomposition:
- Package mac_table_pkg holds:
  - CRC32 polynomial/init constants.
  - Entry struct: valid, flag, outport, mac, age.
  - FSM state enum.
  - Function for the bucket index.
- One natural sub-module: mac_hash_crc48, a combinational CRC32 of a 48-bit key, instantiated at both accept ports.

Test Plan:
- Reset, then hold i_rst low → o_busy=1 for 16 cycles, readys then 1. Seek 0x001122334455 → hit=0 with id echoed at T+2.
- Update MAC 0x001122334455 outport=5 flag=1, then seek id=3 → o_seek_valid at T+2 with hit=1, outport=5, flag=1, id=3.
- Update the same MAC with outport=9 → seek returns 9; o_overflow_cnt stays 0.
- Five distinct MACs hashing to one bucket (P_WAYS=4) → first-written entry evicted (seek misses it), o_overflow_cnt=1, other four hit.
- Seek and update same cycle → update stalls one cycle. Seek issued the cycle after update accept, same MAC → returns new outport (bypass).
- i_flush after 4 entries → o_busy 16 cycles, all seeks miss. With MAC_TABLE_AGING_EN and P_AGE_WIDTH=2: an unused entry misses after 4 ticks, an entry refreshed by a hit each tick stays.

Source files
------------

// File: rtl/mac_table_pkg.sv
// Shared types and constants for the MAC hash table: CRC32 constants, the
// stored entry layout, sweep FSM states and the bucket-index helper.
package mac_table_pkg;

    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // Entry fields are sized for the widest supported configuration.
    localparam int unsigned MAC_OUTPORT_WMAX = 16;
    localparam int unsigned MAC_AGE_WMAX     = 16;

    typedef struct packed {
        logic                        valid;
        logic                        flag;
        logic [MAC_OUTPORT_WMAX-1:0] outport;
        logic [47:0]                 mac;
        logic [MAC_AGE_WMAX-1:0]     age;
    } mac_entry_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_AGE   = 2'd3
    } mac_state_e;

    function automatic logic [31:0] bucket_index(input logic [31:0] crc,
                                                 input int unsigned addr_width);
        return crc & ((32'd1 << addr_width) - 32'd1);
    endfunction

endpackage

// File: rtl/mac_hash_crc48.sv
// Combinational reflected Ethernet CRC32 of a 48-bit MAC, byte [47:40] first,
// each byte LSB first, with final inversion.
module mac_hash_crc48
    import mac_table_pkg::*;
(
    input  logic [47:0] key,
    output logic [31:0] crc
);

    logic [31:0] c;

    always_comb begin
        c = CRC32_INIT;
        for (int unsigned b = 0; b < 6; b++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (c[0] ^ key[40 - 8*b + k])
                    c = (c >> 1) ^ CRC32_POLY_REFL;
                else
                    c = c >> 1;
            end
        end
        crc = ~c;
    end

endmodule

// File: rtl/mac_hash_table.sv
// CRC32-hashed set-associative MAC -> outport table with update/seek pipelines
// and an init/flush sweep. Define MAC_TABLE_AGING_EN to add entry aging (i_age_tick).
module mac_hash_table
    import mac_table_pkg::*;
#(
    parameter int unsigned P_OUTPORT_WIDTH = 4,
    parameter int unsigned P_ADDR_WIDTH    = 4,
    parameter int unsigned P_WAYS          = 4,
    parameter int unsigned P_ID_WIDTH      = 3,
    parameter int unsigned P_AGE_WIDTH     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_update_valid,
    output logic                       o_update_ready,
    input  logic [47:0]                i_update_dest_mac,
    input  logic [P_OUTPORT_WIDTH-1:0] i_update_outport,
    input  logic                       i_update_flag,
    input  logic                       i_seek_valid,
    output logic                       o_seek_ready,
    input  logic [47:0]                i_seek_dest_mac,
    input  logic [P_ID_WIDTH-1:0]      i_seek_id,
    output logic                       o_seek_valid,
    output logic                       o_seek_hit,
    output logic                       o_seek_flag,
    output logic [P_OUTPORT_WIDTH-1:0] o_seek_outport,
    output logic [P_ID_WIDTH-1:0]      o_seek_id,
    input  logic                       i_flush,
`ifdef MAC_TABLE_AGING_EN
    input  logic                       i_age_tick,
`endif
    output logic                       o_busy,
    output logic [15:0]                o_overflow_cnt
);

    localparam int unsigned NBKT  = 1 << P_ADDR_WIDTH;
    localparam int unsigned WAY_W = (P_WAYS > 1) ? $clog2(P_WAYS) : 1;

    mac_entry_t              tbl  [NBKT][P_WAYS];
    logic [WAY_W-1:0]        vptr [NBKT];
    mac_state_e              state;
    logic [P_ADDR_WIDTH-1:0] sweep_idx;
    logic [15:0]             ovf_cnt;

    logic [31:0] seek_crc, upd_crc;
    mac_hash_crc48 u_seek_crc (.key(i_seek_dest_mac),   .crc(seek_crc));
    mac_hash_crc48 u_upd_crc  (.key(i_update_dest_mac), .crc(upd_crc));

    logic                       seek_s1_v, upd_s1_v;
    logic [47:0]                seek_s1_mac, upd_s1_mac;
    logic [P_ID_WIDTH-1:0]      seek_s1_id;
    logic [P_ADDR_WIDTH-1:0]    seek_s1_bkt, upd_s1_bkt;
    logic [P_OUTPORT_WIDTH-1:0] upd_s1_outport;
    logic                       upd_s1_flag;

    logic age_req, age_go, idle_open, seek_acc, upd_acc;

`ifdef MAC_TABLE_AGING_EN
    logic tick_pend;
    assign age_req = tick_pend | i_age_tick;
`else
    assign age_req = 1'b0;
`endif

    // Aging only starts once both pipelines are empty so the sweep never races a write.
    assign age_go    = (state == ST_IDLE) && age_req && !i_flush && !seek_s1_v && !upd_s1_v;
    assign idle_open = (state == ST_IDLE) && !age_req;

    assign o_seek_ready   = idle_open;
    assign o_update_ready = idle_open && !upd_s1_v && !i_seek_valid;
    assign o_busy         = (state != ST_IDLE);
    assign o_overflow_cnt = ovf_cnt;
    assign seek_acc       = i_seek_valid && o_seek_ready;
    assign upd_acc        = i_update_valid && o_update_ready;

    logic             upd_match_f, upd_free_f, upd_evict;
    logic [WAY_W-1:0] upd_match_w, upd_free_w, upd_way;
    mac_entry_t       upd_entry;

    always_comb begin
        upd_match_f = 1'b0;
        upd_free_f  = 1'b0;
        upd_match_w = '0;
        upd_free_w  = '0;
        for (int unsigned w = 0; w < P_WAYS; w++) begin
            if (!upd_match_f && tbl[upd_s1_bkt][w].valid && tbl[upd_s1_bkt][w].mac == upd_s1_mac) begin
                upd_match_f = 1'b1;
                upd_match_w = WAY_W'(w);
            end
            if (!upd_free_f && !tbl[upd_s1_bkt][w].valid) begin
                upd_free_f = 1'b1;
                upd_free_w = WAY_W'(w);
            end
        end
        upd_evict = !upd_match_f && !upd_free_f;
        upd_way   = upd_match_f ? upd_match_w : (upd_free_f ? upd_free_w : vptr[upd_s1_bkt]);

        upd_entry         = '0;
        upd_entry.valid   = 1'b1;
        upd_entry.flag    = upd_s1_flag;
        upd_entry.outport = MAC_OUTPORT_WMAX'(upd_s1_outport);
        upd_entry.mac     = upd_s1_mac;
    end

    logic       seek_hit;
    mac_entry_t seek_sel, cand;
`ifdef MAC_TABLE_AGING_EN
    logic [WAY_W-1:0] seek_way;
`endif

    // Compare sees the bucket as it will be after a same-cycle update write.
    always_comb begin
        seek_hit = 1'b0;
        seek_sel = '0;
        cand     = '0;
`ifdef MAC_TABLE_AGING_EN
        seek_way = '0;
`endif
        for (int unsigned w = 0; w < P_WAYS; w++) begin
            cand = tbl[seek_s1_bkt][w];
            if (upd_s1_v && upd_s1_bkt == seek_s1_bkt && upd_way == WAY_W'(w))
                cand = upd_entry;
            if (!seek_hit && cand.valid && cand.mac == seek_s1_mac) begin
                seek_hit = 1'b1;
                seek_sel = cand;
`ifdef MAC_TABLE_AGING_EN
                seek_way = WAY_W'(w);
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_INIT;
            sweep_idx      <= '0;
            ovf_cnt        <= '0;
            seek_s1_v      <= 1'b0;
            upd_s1_v       <= 1'b0;
            o_seek_valid   <= 1'b0;
            o_seek_hit     <= 1'b0;
            o_seek_flag    <= 1'b0;
            o_seek_outport <= '0;
            o_seek_id      <= '0;
`ifdef MAC_TABLE_AGING_EN
            tick_pend      <= 1'b0;
`endif
        end else begin
            seek_s1_v <= seek_acc;
            if (seek_acc) begin
                seek_s1_mac <= i_seek_dest_mac;
                seek_s1_id  <= i_seek_id;
                seek_s1_bkt <= P_ADDR_WIDTH'(bucket_index(seek_crc, P_ADDR_WIDTH));
            end
            upd_s1_v <= upd_acc;
            if (upd_acc) begin
                upd_s1_mac     <= i_update_dest_mac;
                upd_s1_outport <= i_update_outport;
                upd_s1_flag    <= i_update_flag;
                upd_s1_bkt     <= P_ADDR_WIDTH'(bucket_index(upd_crc, P_ADDR_WIDTH));
            end

            o_seek_valid   <= seek_s1_v;
            o_seek_hit     <= seek_s1_v && seek_hit;
            o_seek_flag    <= seek_s1_v && seek_hit && seek_sel.flag;
            o_seek_outport <= (seek_s1_v && seek_hit) ? seek_sel.outport[P_OUTPORT_WIDTH-1:0] : '0;
            o_seek_id      <= seek_s1_v ? seek_s1_id : '0;

`ifdef MAC_TABLE_AGING_EN
            if (seek_s1_v && seek_hit)
                tbl[seek_s1_bkt][seek_way].age <= '0;
            if (age_go)
                tick_pend <= 1'b0;
            else if (i_age_tick)
                tick_pend <= 1'b1;
`endif

            if (upd_s1_v) begin
                tbl[upd_s1_bkt][upd_way] <= upd_entry;
                if (upd_evict) begin
                    vptr[upd_s1_bkt] <= (vptr[upd_s1_bkt] == WAY_W'(P_WAYS - 1)) ? '0
                                                                                 : vptr[upd_s1_bkt] + 1'b1;
                    if (ovf_cnt != '1)
                        ovf_cnt <= ovf_cnt + 16'd1;
                end
            end

            // Sweep writes come last so they override a racing update to the same bucket.
            case (state)
                ST_IDLE: begin
                    if (i_flush) begin
                        state     <= ST_FLUSH;
                        sweep_idx <= '0;
                    end else if (age_go) begin
                        state     <= ST_AGE;
                        sweep_idx <= '0;
                    end
                end
                default: begin
                    if (state == ST_AGE) begin
                        for (int unsigned w = 0; w < P_WAYS; w++) begin
                            if (tbl[sweep_idx][w].valid) begin
                                if (tbl[sweep_idx][w].age[P_AGE_WIDTH-1:0] == '1)
                                    tbl[sweep_idx][w].valid <= 1'b0;
                                else
                                    tbl[sweep_idx][w].age <= tbl[sweep_idx][w].age + 1'b1;
                            end
                        end
                    end else begin
                        for (int unsigned w = 0; w < P_WAYS; w++)
                            tbl[sweep_idx][w].valid <= 1'b0;
                        vptr[sweep_idx] <= '0;
                    end
                    if (i_flush) begin
                        sweep_idx <= '0;
                        if (state == ST_AGE)
                            state <= ST_FLUSH;
                    end else if (sweep_idx == '1) begin
                        state <= ST_IDLE;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_hash_table.sv
// Directed self-checking bench for mac_hash_table; the aging steps are built
// only when MAC_TABLE_AGING_EN is defined.
module tb_mac_hash_table;

`ifdef MAC_TABLE_AGING_EN
    localparam int unsigned AGE_W = 2;
`else
    localparam int unsigned AGE_W = 8;
`endif
    localparam logic [47:0] MAC_A = 48'h001122334455;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_update_valid = 1'b0;
    logic        o_update_ready;
    logic [47:0] i_update_dest_mac = '0;
    logic [3:0]  i_update_outport = '0;
    logic        i_update_flag = 1'b0;
    logic        i_seek_valid = 1'b0;
    logic        o_seek_ready;
    logic [47:0] i_seek_dest_mac = '0;
    logic [2:0]  i_seek_id = '0;
    logic        o_seek_valid, o_seek_hit, o_seek_flag;
    logic [3:0]  o_seek_outport;
    logic [2:0]  o_seek_id;
    logic        i_flush = 1'b0;
    logic        o_busy;
    logic [15:0] o_overflow_cnt;
`ifdef MAC_TABLE_AGING_EN
    logic        i_age_tick = 1'b0;
`endif

    mac_hash_table #(
        .P_OUTPORT_WIDTH(4),
        .P_ADDR_WIDTH   (4),
        .P_WAYS         (4),
        .P_ID_WIDTH     (3),
        .P_AGE_WIDTH    (AGE_W)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_update_valid   (i_update_valid),
        .o_update_ready   (o_update_ready),
        .i_update_dest_mac(i_update_dest_mac),
        .i_update_outport (i_update_outport),
        .i_update_flag    (i_update_flag),
        .i_seek_valid     (i_seek_valid),
        .o_seek_ready     (o_seek_ready),
        .i_seek_dest_mac  (i_seek_dest_mac),
        .i_seek_id        (i_seek_id),
        .o_seek_valid     (o_seek_valid),
        .o_seek_hit       (o_seek_hit),
        .o_seek_flag      (o_seek_flag),
        .o_seek_outport   (o_seek_outport),
        .o_seek_id        (o_seek_id),
        .i_flush          (i_flush),
`ifdef MAC_TABLE_AGING_EN
        .i_age_tick       (i_age_tick),
`endif
        .o_busy           (o_busy),
        .o_overflow_cnt   (o_overflow_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent model: MSB-first CRC on bit-reversed input; reflected result = bit reverse.
    function automatic logic [3:0] model_bucket(input logic [47:0] mac);
        logic [31:0] c;
        logic [7:0]  by;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            by = mac[47 - 8*i -: 8];
            for (int k = 0; k < 8; k++) begin
                if (c[31] ^ by[k]) c = (c << 1) ^ 32'h04C11DB7;
                else               c = c << 1;
            end
        end
        c = ~c;
        return {c[28], c[29], c[30], c[31]};
    endfunction

    task automatic do_seek(input logic [47:0] mac, input logic [2:0] id, input logic hit,
                           input logic [3:0] outp, input logic flag, input string tag);
        int unsigned guard = 0;
        @(negedge i_clk);
        while (!o_seek_ready && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        i_seek_valid    = 1'b1;
        i_seek_dest_mac = mac;
        i_seek_id       = id;
        @(negedge i_clk);
        i_seek_valid = 1'b0;
        @(negedge i_clk);
        check(tag, {o_seek_valid, o_seek_hit, o_seek_flag, o_seek_outport, o_seek_id},
                   {1'b1, hit, flag, outp, id});
    endtask

    task automatic do_update(input logic [47:0] mac, input logic [3:0] outp, input logic flag,
                             input string tag);
        int unsigned guard = 0;
        @(negedge i_clk);
        while (!o_update_ready && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        check(tag, o_update_ready, 1'b1);
        i_update_valid    = 1'b1;
        i_update_dest_mac = mac;
        i_update_outport  = outp;
        i_update_flag     = flag;
        @(negedge i_clk);
        i_update_valid = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        int unsigned n = 0;
        while (o_busy && n < 100) begin
            n++;
            @(negedge i_clk);
        end
        check(tag, n, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] ev_mac [5];
        logic [47:0] cmac;
        logic [3:0]  tgt;
        logic        sv_seen;
        int          found;

        repeat (3) @(negedge i_clk);
        check("reset_state", {o_busy, o_seek_ready, o_update_ready, o_seek_valid, o_seek_hit,
                              o_seek_flag, o_seek_outport, o_seek_id, o_overflow_cnt},
                             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'h0, 16'h0});
        i_rst = 1'b0;
        count_busy("init_busy_cycles");
        check("readys_after_init", {o_seek_ready, o_update_ready}, 2'b11);

        do_seek(MAC_A, 3'd2, 1'b0, 4'h0, 1'b0, "seek_empty_miss");

        do_update(MAC_A, 4'h5, 1'b1, "upd_a_rdy");
        do_seek(MAC_A, 3'd3, 1'b1, 4'h5, 1'b1, "seek_a_hit5");

        do_update(MAC_A, 4'h9, 1'b1, "upd_a2_rdy");
        do_seek(MAC_A, 3'd4, 1'b1, 4'h9, 1'b1, "seek_a_hit9");
        check("ovf_after_overwrite", o_overflow_cnt, 16'd0);

        // Five keys sharing one bucket, distinct from MAC_A's bucket.
        tgt   = model_bucket(MAC_A) + 4'd1;
        found = 0;
        for (int k = 0; k < 4000 && found < 5; k++) begin
            cmac = 48'h0A0000000000 + 48'(k);
            if (model_bucket(cmac) == tgt) begin
                ev_mac[found] = cmac;
                found++;
            end
        end
        check("collision_search", found, 5);
        for (int i = 0; i < 5; i++)
            do_update(ev_mac[i], 4'(i + 1), 1'b0, "upd_evict_rdy");
        do_seek(ev_mac[0], 3'd0, 1'b0, 4'h0, 1'b0, "evicted_miss");
        for (int i = 1; i < 5; i++)
            do_seek(ev_mac[i], 3'(i), 1'b1, 4'(i + 1), 1'b0, "evict_survivor_hit");
        check("ovf_after_evict", o_overflow_cnt, 16'd1);

        // Seek and update requested together: seek wins, update waits a cycle.
        @(negedge i_clk);
        i_seek_valid      = 1'b1;
        i_seek_dest_mac   = MAC_A;
        i_seek_id         = 3'd6;
        i_update_valid    = 1'b1;
        i_update_dest_mac = MAC_A;
        i_update_outport  = 4'h7;
        i_update_flag     = 1'b1;
        #1;
        check("simul_readys", {o_seek_ready, o_update_ready}, 2'b10);
        @(negedge i_clk);
        i_seek_valid = 1'b0;
        #1;
        check("simul_upd_ready_next", o_update_ready, 1'b1);
        @(negedge i_clk);
        i_update_valid = 1'b0;
        check("simul_seek_result", {o_seek_valid, o_seek_hit, o_seek_flag, o_seek_outport, o_seek_id},
                                   {1'b1, 1'b1, 1'b1, 4'h9, 3'd6});
        do_seek(MAC_A, 3'd1, 1'b1, 4'h7, 1'b1, "seek_after_stalled_upd");

        // Seek issued the cycle after the update accept.
        @(negedge i_clk);
        check("byp_upd_ready", o_update_ready, 1'b1);
        i_update_valid    = 1'b1;
        i_update_dest_mac = MAC_A;
        i_update_outport  = 4'hC;
        i_update_flag     = 1'b1;
        @(negedge i_clk);
        i_update_valid = 1'b0;
        check("upd_ready_gap", o_update_ready, 1'b0);
        i_seek_valid    = 1'b1;
        i_seek_dest_mac = MAC_A;
        i_seek_id       = 3'd5;
        @(negedge i_clk);
        i_seek_valid = 1'b0;
        @(negedge i_clk);
        check("bypass_seek", {o_seek_valid, o_seek_hit, o_seek_flag, o_seek_outport, o_seek_id},
                             {1'b1, 1'b1, 1'b1, 4'hC, 3'd5});

        // Flush with a restart part-way through the sweep.
        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        count_busy("flush_busy_cycles");
        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        repeat (4) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        count_busy("flush_restart_busy_cycles");
        do_seek(MAC_A, 3'd7, 1'b0, 4'h0, 1'b0, "flushed_a_miss");
        for (int i = 1; i < 5; i++)
            do_seek(ev_mac[i], 3'(i), 1'b0, 4'h0, 1'b0, "flushed_ev_miss");
        check("ovf_kept_by_flush", o_overflow_cnt, 16'd1);

        // Reset with a seek in flight: its result must never appear.
        do_update(MAC_A, 4'h3, 1'b0, "upd_pre_reset_rdy");
        @(negedge i_clk);
        i_seek_valid    = 1'b1;
        i_seek_dest_mac = MAC_A;
        i_seek_id       = 3'd2;
        @(negedge i_clk);
        i_seek_valid = 1'b0;
        i_rst        = 1'b1;
        sv_seen      = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            sv_seen = sv_seen | o_seek_valid;
        end
        check("reset_drops_seek", {sv_seen, o_overflow_cnt}, {1'b0, 16'h0});
        i_rst = 1'b0;
        count_busy("reinit_busy_cycles");
        do_seek(MAC_A, 3'd2, 1'b0, 4'h0, 1'b0, "reinit_a_miss");

`ifdef MAC_TABLE_AGING_EN
        do_update(MAC_A, 4'h1, 1'b0, "age_upd_a_rdy");
        do_update(ev_mac[1], 4'h2, 1'b1, "age_upd_b_rdy");
        for (int t = 0; t < 4; t++) begin
            do_seek(ev_mac[1], 3'd4, 1'b1, 4'h2, 1'b1, "age_refresh_hit");
            @(negedge i_clk);
            i_age_tick = 1'b1;
            @(negedge i_clk);
            i_age_tick = 1'b0;
            count_busy("age_busy_cycles");
        end
        do_seek(MAC_A, 3'd1, 1'b0, 4'h0, 1'b0, "aged_out_miss");
        do_seek(ev_mac[1], 3'd3, 1'b1, 4'h2, 1'b1, "refreshed_stays_hit");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
